rename_register_file: RTL
=========================

Name: rename_register_file

Overview:
- Architectural register file with per-register rename state (busy bit plus producer tag), sitting between the decoder and the reorder buffer / reservation stations.
- On each accepted issue it does three things:
  - reads rs1/rs2 and returns either a value or a producer tag;
  - marks rd as busy, tagged with the issuing instruction's PC;
  - forwards the PC and rd to the ROB for allocation.
- It consumes the ROB commit stream to write back results and clear busy bits.
- It flushes all rename state on a ROB exception.

Parameters:
- RegCount, 32, number of architectural registers (x0 hardwired zero)
- RdLength, 4, MSB index of register index fields (5 bits)
- DataLength, 31, MSB index of data (32 bits)
- PcLength, 31, MSB index of PC/tag (32 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- is_issue_from_decoder  in  1  decoder presents an instruction this cycle
- pc_from_decoder  in  32  instruction PC; also used as its rename tag
- rd_from_decoder  in  5  destination register
- has_rd_from_decoder  in  1  instruction writes rd
- rs1_from_decoder  in  5  source 1 index
- rs2_from_decoder  in  5  source 2 index
- is_ready_from_rob  in  1  ROB can accept an entry
- is_commit_from_rob  in  1  commit valid
- commit_pc_from_rob  in  32  tag of committing instruction
- commit_rd_from_rob  in  5  destination of committing instruction
- commit_data_from_rob  in  32  result
- is_exception_from_rob  in  1  flush request
- is_stall_to_decoder  out  1  issue not accepted this cycle (combinational)
- is_ready_to_rob  out  1  allocation pulse to ROB (registered)
- pc_to_rob  out  32  allocated PC
- rd_to_rob  out  5  allocated rd (0 when has_rd low)
- is_issue_to_rs  out  1  operand bundle valid (registered)
- pc_to_rs  out  32  PC of operand bundle
- rs1_busy_to_rs / rs2_busy_to_rs  out  1  operand still pending
- rs1_value_to_rs / rs2_value_to_rs  out  32  value when not busy, 0 when busy
- rs1_tag_to_rs / rs2_tag_to_rs  out  32  producer PC when busy, 0 when not busy

Behaviour:
- Reset (rst low, asynchronous):
  - all registers, busy bits and tags are 0;
  - all registered outputs are 0;
  - state is held until rst rises.
- Accept condition: accept = is_issue_from_decoder & is_ready_from_rob & !is_exception_from_rob.
- is_stall_to_decoder = is_issue_from_decoder & !accept.
- Latency: on an accepting edge, the ROB and RS outputs update together and are valid for exactly one cycle. With no accept, is_ready_to_rob = is_issue_to_rs = 0 and the other outputs hold their values.
- Operand read (per source, evaluated on the accepting edge, using state before this cycle's rename):
  - index 0: busy=0, value=0.
  - register not busy: value = regfile[rs].
  - register busy, and is_commit_from_rob with commit_pc == tag[rs]: same-cycle bypass gives busy=0, value=commit_data.
  - otherwise: busy=1, tag=tag[rs].
- Self-dependency: when rs1 or rs2 equals rd, the operand sees the previous mapping, not the new tag.
- Rename: if accepted, has_rd=1 and rd!=0, then busy[rd]<=1 and tag[rd]<=pc_from_decoder.
- Commit (whenever is_commit_from_rob):
  - if commit_rd!=0, regfile[commit_rd] <= commit_data;
  - busy[commit_rd] is cleared only if tag[commit_rd]==commit_pc, so a younger rename is not cleared.
- Same-cycle commit and rename to the same rd: the data write happens, and the rename wins for busy and tag.
- Exception:
  - a commit in the same cycle is written first;
  - then every busy bit clears (tags are don't-care);
  - any issue in that cycle is dropped, and both output pulses are 0 on the next cycle.
- x0 is never written and never busy. An instruction with rd=0 is still sent to the ROB with rd_to_rob=0.
- There is no back-pressure from the RS side; the decoder must hold its inputs while stalled.

Decomposition:
- parameters.v supplies DataLength, PcLength, True/False and Zero. Add RegCount and RegIndexLength there.
- One sub-module is natural: rename_operand_read (combinational lookup plus commit bypass), instanced twice for rs1 and rs2.

Test Plan:
- Reset mid-run:
  - stimulus: busy x5 set, then rst low asynchronously between clock edges;
  - response: busy flags, is_ready_to_rob and is_issue_to_rs go 0 immediately, and a later read of x5 returns 0 with busy=0.
- Issue and commit with bypass:
  - stimulus: issue PC=0x100, rd=x3; then issue PC=0x104 with rs1=x3;
  - response 1: pc_to_rob=0x100, rd_to_rob=3, and the second bundle shows rs1_busy=1, tag=0x100;
  - stimulus: commit PC=0x100, data=0x55 in the same cycle as issuing PC=0x108 with rs2=x3;
  - response 2: rs2_busy=0, value=0x55.
- Younger rename protected:
  - stimulus: issue 0x200 to x4, issue 0x204 to x4, commit 0x200 with data=7;
  - response: x4 stays busy with tag 0x204; after commit 0x204 with data=9, a read returns 9.
- Self-dependency and x0:
  - stimulus: issue add x6,x6,x0 at 0x300 with x6=0x11;
  - response: rs1 value=0x11 with busy=0, rs2 value=0, then x6 busy with tag 0x300; an issue writing x0 leaves x0 at 0 and not busy.
- Stall:
  - stimulus: is_ready_from_rob=0 with is_issue=1;
  - response: is_stall_to_decoder=1, no output pulses, no busy change.
- Exception:
  - stimulus: x7 and x8 busy; exception together with commit of x7 (data=0x1234) and an issue of 0x400;
  - response: x7=0x1234, x8 not busy, the 0x400 issue is dropped, and no pulses appear on the next cycle.

Source files
------------

// File: rtl/rename_register_file_pkg.sv
// Shared sizing and constants for the rename register file slice.
package rename_register_file_pkg;

    localparam int RegCount       = 32;
    localparam int RegIndexLength = 4;
    localparam int DataLength     = 31;
    localparam int PcLength       = 31;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam logic [DataLength:0] Zero = '0;

endpackage

// File: rtl/rename_operand_read.sv
// Source operand lookup: resolves one source register to either a ready
// value or the producer tag, with a same-cycle bypass from the commit stream.
module rename_operand_read
    import rename_register_file_pkg::*;
(
    input  logic [RegIndexLength:0] rs,
    input  logic [DataLength:0]     reg_value,
    input  logic                    reg_busy,
    input  logic [PcLength:0]       reg_tag,
    input  logic                    is_commit,
    input  logic [PcLength:0]       commit_pc,
    input  logic [DataLength:0]     commit_data,
    output logic                    busy,
    output logic [DataLength:0]     value,
    output logic [PcLength:0]       tag
);

    // x0 reads zero; a pending producer committing right now is taken from the commit bus
    always_comb begin
        busy  = False;
        value = Zero;
        tag   = '0;
        if (rs == '0) begin
            value = Zero;
        end else if (!reg_busy) begin
            value = reg_value;
        end else if (is_commit && (commit_pc == reg_tag)) begin
            value = commit_data;
        end else begin
            busy = True;
            tag  = reg_tag;
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with busy/tag rename state. Renames rd on
// issue, hands operands to the reservation stations, allocates into the ROB,
// retires commits and flushes rename state on exceptions.
module rename_register_file
    import rename_register_file_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    is_issue_from_decoder,
    input  logic [PcLength:0]       pc_from_decoder,
    input  logic [RegIndexLength:0] rd_from_decoder,
    input  logic                    has_rd_from_decoder,
    input  logic [RegIndexLength:0] rs1_from_decoder,
    input  logic [RegIndexLength:0] rs2_from_decoder,
    input  logic                    is_ready_from_rob,
    input  logic                    is_commit_from_rob,
    input  logic [PcLength:0]       commit_pc_from_rob,
    input  logic [RegIndexLength:0] commit_rd_from_rob,
    input  logic [DataLength:0]     commit_data_from_rob,
    input  logic                    is_exception_from_rob,
    output logic                    is_stall_to_decoder,
    output logic                    is_ready_to_rob,
    output logic [PcLength:0]       pc_to_rob,
    output logic [RegIndexLength:0] rd_to_rob,
    output logic                    is_issue_to_rs,
    output logic [PcLength:0]       pc_to_rs,
    output logic                    rs1_busy_to_rs,
    output logic [DataLength:0]     rs1_value_to_rs,
    output logic [PcLength:0]       rs1_tag_to_rs,
    output logic                    rs2_busy_to_rs,
    output logic [DataLength:0]     rs2_value_to_rs,
    output logic [PcLength:0]       rs2_tag_to_rs
);

    logic [DataLength:0] regfile [RegCount];
    logic [PcLength:0]   tag     [RegCount];
    logic [RegCount-1:0] busy;

    logic accept;
    logic rename;

    logic                rs1_busy;
    logic [DataLength:0] rs1_value;
    logic [PcLength:0]   rs1_tag;
    logic                rs2_busy;
    logic [DataLength:0] rs2_value;
    logic [PcLength:0]   rs2_tag;

    assign accept              = is_issue_from_decoder & is_ready_from_rob & ~is_exception_from_rob;
    assign is_stall_to_decoder = is_issue_from_decoder & ~accept;
    assign rename              = accept & has_rd_from_decoder & (rd_from_decoder != '0);

    rename_operand_read u_rs1_read (
        .rs          (rs1_from_decoder),
        .reg_value   (regfile[rs1_from_decoder]),
        .reg_busy    (busy[rs1_from_decoder]),
        .reg_tag     (tag[rs1_from_decoder]),
        .is_commit   (is_commit_from_rob),
        .commit_pc   (commit_pc_from_rob),
        .commit_data (commit_data_from_rob),
        .busy        (rs1_busy),
        .value       (rs1_value),
        .tag         (rs1_tag)
    );

    rename_operand_read u_rs2_read (
        .rs          (rs2_from_decoder),
        .reg_value   (regfile[rs2_from_decoder]),
        .reg_busy    (busy[rs2_from_decoder]),
        .reg_tag     (tag[rs2_from_decoder]),
        .is_commit   (is_commit_from_rob),
        .commit_pc   (commit_pc_from_rob),
        .commit_data (commit_data_from_rob),
        .busy        (rs2_busy),
        .value       (rs2_value),
        .tag         (rs2_tag)
    );

    // Architectural state: commit write-back first, then flush or rename so a rename of the same rd wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RegCount; i++) begin
                regfile[i] <= Zero;
                tag[i]     <= '0;
            end
            busy <= '0;
        end else begin
            if (is_commit_from_rob && (commit_rd_from_rob != '0)) begin
                regfile[commit_rd_from_rob] <= commit_data_from_rob;
                if (tag[commit_rd_from_rob] == commit_pc_from_rob) begin
                    busy[commit_rd_from_rob] <= False;
                end
            end
            if (is_exception_from_rob) begin
                busy <= '0;
            end else if (rename) begin
                busy[rd_from_decoder] <= True;
                tag[rd_from_decoder]  <= pc_from_decoder;
            end
        end
    end

    // ROB allocation and operand bundle: one-cycle pulses, payload held between accepts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_ready_to_rob <= False;
            pc_to_rob       <= '0;
            rd_to_rob       <= '0;
            is_issue_to_rs  <= False;
            pc_to_rs        <= '0;
            rs1_busy_to_rs  <= False;
            rs1_value_to_rs <= Zero;
            rs1_tag_to_rs   <= '0;
            rs2_busy_to_rs  <= False;
            rs2_value_to_rs <= Zero;
            rs2_tag_to_rs   <= '0;
        end else begin
            is_ready_to_rob <= accept;
            is_issue_to_rs  <= accept;
            if (accept) begin
                pc_to_rob       <= pc_from_decoder;
                rd_to_rob       <= has_rd_from_decoder ? rd_from_decoder : '0;
                pc_to_rs        <= pc_from_decoder;
                rs1_busy_to_rs  <= rs1_busy;
                rs1_value_to_rs <= rs1_value;
                rs1_tag_to_rs   <= rs1_tag;
                rs2_busy_to_rs  <= rs2_busy;
                rs2_value_to_rs <= rs2_value;
                rs2_tag_to_rs   <= rs2_tag;
            end
        end
    end

endmodule
